// File: rtl/uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_check
// Description : UART receive frame checker. Sits behind the RX sampling
//               stage: after the start bit is validated it deserialises
//               DATA_WIDTH data bits LSB-first, checks an optional parity
//               bit and one or two stop bits, emits a one-cycle frame strobe
//               with data and per-frame error flags, and keeps saturating
//               parity/stop error counters.
// Ports       : clk_i           - clock, rising edge
//               rst_ni          - synchronous active-low reset
//               frame_start_i   - start bit validated (ignored unless idle)
//               sample_vld_i    - sampled_bit_i valid this cycle
//               sampled_bit_i   - majority-sampled line value
//               cfg_par_en_i    - parity bit present
//               cfg_par_odd_i   - odd (1) / even (0) parity
//               cfg_two_stop_i  - two stop bits
//               err_clr_i       - clear both error counters (wins over inc)
//               busy_o          - frame in progress
//               rx_data_o       - last received data word
//               frame_vld_o     - one-cycle frame complete strobe
//               par_err_o       - parity error of last frame
//               stp_err_o       - stop error of last frame
//               par_err_cnt_o   - saturating parity error count
//               stp_err_cnt_o   - saturating stop error count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  frame_start_i,
    input  logic                  sample_vld_i,
    input  logic                  sampled_bit_i,
    input  logic                  cfg_par_en_i,
    input  logic                  cfg_par_odd_i,
    input  logic                  cfg_two_stop_i,
    input  logic                  err_clr_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  frame_vld_o,
    output logic                  par_err_o,
    output logic                  stp_err_o,
    output logic [CNT_WIDTH-1:0]  par_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt_o
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [BW-1:0]         bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  par_acc_q,   par_acc_d;
    logic                  par_flag_q,  par_flag_d;
    logic                  stp_flag_q,  stp_flag_d;
    logic                  stop_idx_q,  stop_idx_d;
    logic                  par_en_q,    par_en_d;
    logic                  two_stop_q,  two_stop_d;
    logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic                  frame_vld_q, frame_vld_d;
    logic                  par_err_q,   par_err_d;
    logic                  stp_err_q,   stp_err_d;
    logic [CNT_WIDTH-1:0]  par_cnt_q,   par_cnt_d;
    logic [CNT_WIDTH-1:0]  stp_cnt_q,   stp_cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            par_flag_q  <= 1'b0;
            stp_flag_q  <= 1'b0;
            stop_idx_q  <= 1'b0;
            par_en_q    <= 1'b0;
            two_stop_q  <= 1'b0;
            rx_data_q   <= '0;
            frame_vld_q <= 1'b0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
            par_cnt_q   <= '0;
            stp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            par_flag_q  <= par_flag_d;
            stp_flag_q  <= stp_flag_d;
            stop_idx_q  <= stop_idx_d;
            par_en_q    <= par_en_d;
            two_stop_q  <= two_stop_d;
            rx_data_q   <= rx_data_d;
            frame_vld_q <= frame_vld_d;
            par_err_q   <= par_err_d;
            stp_err_q   <= stp_err_d;
            par_cnt_q   <= par_cnt_d;
            stp_cnt_q   <= stp_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_acc_d   = par_acc_q;
        par_flag_d  = par_flag_q;
        stp_flag_d  = stp_flag_q;
        stop_idx_d  = stop_idx_q;
        par_en_d    = par_en_q;
        two_stop_d  = two_stop_q;
        rx_data_d   = rx_data_q;
        frame_vld_d = 1'b0;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;
        par_cnt_d   = par_cnt_q;
        stp_cnt_d   = stp_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d    = S_DATA;
                    bit_cnt_d  = '0;
                    par_en_d   = cfg_par_en_i;
                    two_stop_d = cfg_two_stop_i;
                    // Seeding with the odd flag makes a zero result mean
                    // "parity good" for both even and odd modes.
                    par_acc_d  = cfg_par_odd_i;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                    stop_idx_d = 1'b0;
                end
            end
            S_DATA: begin
                if (sample_vld_i) begin
                    // Shift right so the first (LSB) bit ends at bit 0.
                    shift_d   = {sampled_bit_i, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ sampled_bit_i;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (sample_vld_i) begin
                    par_flag_d = par_acc_q ^ sampled_bit_i;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_vld_i) begin
                    stp_flag_d = stp_flag_q | ~sampled_bit_i;
                    if (stop_idx_q == two_stop_q) begin
                        state_d     = S_IDLE;
                        rx_data_d   = shift_q;
                        par_err_d   = par_en_q & par_flag_q;
                        stp_err_d   = stp_flag_q | ~sampled_bit_i;
                        frame_vld_d = 1'b1;
                        if (par_err_d && (par_cnt_q != CNT_MAX)) begin
                            par_cnt_d = par_cnt_q + CNT_WIDTH'(1);
                        end
                        if (stp_err_d && (stp_cnt_q != CNT_MAX)) begin
                            stp_cnt_d = stp_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear takes priority over a coincident increment.
        if (err_clr_i) begin
            par_cnt_d = '0;
            stp_cnt_d = '0;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign rx_data_o     = rx_data_q;
    assign frame_vld_o   = frame_vld_q;
    assign par_err_o     = par_err_q;
    assign stp_err_o     = stp_err_q;
    assign par_err_cnt_o = par_cnt_q;
    assign stp_err_cnt_o = stp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_check
// Description : Directed self-checking bench for uart_rx_frame_check
//               (DATA_WIDTH=8, CNT_WIDTH=4 so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_check;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          sample_vld;
    logic          sampled_bit;
    logic          cfg_par_en;
    logic          cfg_par_odd;
    logic          cfg_two_stop;
    logic          err_clr;
    logic          busy;
    logic [DW-1:0] rx_data;
    logic          frame_vld;
    logic          par_err;
    logic          stp_err;
    logic [CW-1:0] par_cnt;
    logic [CW-1:0] stp_cnt;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .frame_start_i  (frame_start),
        .sample_vld_i   (sample_vld),
        .sampled_bit_i  (sampled_bit),
        .cfg_par_en_i   (cfg_par_en),
        .cfg_par_odd_i  (cfg_par_odd),
        .cfg_two_stop_i (cfg_two_stop),
        .err_clr_i      (err_clr),
        .busy_o         (busy),
        .rx_data_o      (rx_data),
        .frame_vld_o    (frame_vld),
        .par_err_o      (par_err),
        .stp_err_o      (stp_err),
        .par_err_cnt_o  (par_cnt),
        .stp_err_cnt_o  (stp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame; inputs change on falling edges. Config inputs are
    // inverted after frame_start to show they are latched. inj is the data
    // index at which a stray frame_start is injected (-1 for none).
    task automatic send(input logic [7:0] d, input logic pe, input logic po,
                        input logic ts, input logic pb, input logic s0,
                        input logic s1, input bit clr, input int inj,
                        input bit start_last);
        @(negedge clk);
        frame_start  = 1'b1;
        cfg_par_en   = pe;
        cfg_par_odd  = po;
        cfg_two_stop = ts;
        @(negedge clk);
        frame_start  = 1'b0;
        cfg_par_en   = ~pe;
        cfg_par_odd  = ~po;
        cfg_two_stop = ~ts;
        chk("busy_rise", 32'(busy), 32'd1);
        for (int i = 0; i < DW; i++) begin
            sample_vld  = 1'b1;
            sampled_bit = d[i];
            frame_start = (i == inj);
            @(negedge clk);
            frame_start = 1'b0;
            chk("no_vld_data", 32'(frame_vld), 32'd0);
        end
        if (pe) begin
            sampled_bit = pb;
            @(negedge clk);
            chk("no_vld_par", 32'(frame_vld), 32'd0);
        end
        sampled_bit = s0;
        if (ts) begin
            @(negedge clk);
            chk("no_vld_stop1", 32'(frame_vld), 32'd0);
            chk("busy_stop1", 32'(busy), 32'd1);
            sampled_bit = s1;
        end
        err_clr     = clr;
        frame_start = start_last;
        @(negedge clk);
        sample_vld   = 1'b0;
        sampled_bit  = 1'b1;
        err_clr      = 1'b0;
        frame_start  = 1'b0;
        cfg_par_en   = 1'b0;
        cfg_par_odd  = 1'b0;
        cfg_two_stop = 1'b0;
    endtask

    // Checks the completion cycle and the cycle after it.
    task automatic done(input logic [7:0] d, input logic pe_exp, input logic se_exp,
                        input int pc, input int sc);
        chk("frame_vld", 32'(frame_vld), 32'd1);
        chk("rx_data", 32'(rx_data), 32'(d));
        chk("par_err", 32'(par_err), 32'(pe_exp));
        chk("stp_err", 32'(stp_err), 32'(se_exp));
        chk("par_cnt", 32'(par_cnt), 32'(pc));
        chk("stp_cnt", 32'(stp_cnt), 32'(sc));
        chk("busy_fall", 32'(busy), 32'd0);
        @(negedge clk);
        chk("vld_one_cycle", 32'(frame_vld), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("err_hold", 32'(stp_err), 32'(se_exp));
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        sample_vld   = 1'b0;
        sampled_bit  = 1'b1;
        cfg_par_en   = 1'b0;
        cfg_par_odd  = 1'b0;
        cfg_two_stop = 1'b0;
        err_clr      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_vld", 32'(frame_vld), 32'd0);
        chk("rst_perr", 32'(par_err), 32'd0);
        chk("rst_serr", 32'(stp_err), 32'd0);
        chk("rst_pcnt", 32'(par_cnt), 32'd0);
        chk("rst_scnt", 32'(stp_cnt), 32'd0);
        rst_n = 1'b1;

        // 0xA5, no parity, one good stop
        send(8'hA5, 0, 0, 0, 0, 1, 1, 0, -1, 0);
        done(8'hA5, 0, 0, 0, 0);

        // Even parity on 0xA5 (four ones): parity bit 1 is wrong, 0 is right
        send(8'hA5, 1, 0, 0, 1, 1, 1, 0, -1, 0);
        done(8'hA5, 1, 0, 1, 0);
        send(8'hA5, 1, 0, 0, 0, 1, 1, 0, -1, 0);
        done(8'hA5, 0, 0, 1, 0);

        // Odd parity, two stops, 0x3C (four ones) + parity 1 = good; stop2 bad
        send(8'h3C, 1, 1, 1, 1, 1, 0, 0, -1, 0);
        done(8'h3C, 0, 1, 1, 1);

        // Stop errors up to and past saturation (all-ones = 15)
        for (int i = 0; i < 19; i++) begin
            send(8'(i * 7), 0, 0, 0, 0, 0, 1, 0, -1, 0);
            done(8'(i * 7), 0, 1, 1, (i + 2 > 15) ? 15 : i + 2);
        end

        // err_clr coincident with an error completion: clear wins
        send(8'hC3, 1, 0, 0, 1, 0, 1, 1, -1, 0);
        done(8'hC3, 1, 1, 0, 0);

        // Reset after four data samples aborts the frame
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_vld  = 1'b1;
            sampled_bit = i[0];
            @(negedge clk);
        end
        sample_vld = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_vld", 32'(frame_vld), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_novld", 32'(frame_vld), 32'd0);
        send(8'h5A, 0, 0, 0, 0, 1, 1, 0, -1, 0);
        done(8'h5A, 0, 0, 0, 0);

        // sample_vld in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            sample_vld  = 1'b1;
            sampled_bit = i[0];
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_vld", 32'(frame_vld), 32'd0);
        end
        sample_vld  = 1'b0;
        sampled_bit = 1'b1;
        @(negedge clk);
        chk("idle_data", 32'(rx_data), 32'h5A);

        // frame_start during DATA and with the last stop sample are ignored
        send(8'h96, 0, 0, 0, 0, 1, 1, 0, 3, 1);
        done(8'h96, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
